alu_accum: RTL and testbench

Parametrised successor to the 4-bit switch-driven ALU and 8-bit result register. It merges the ALU and the result register into one block: a WIDTH-bit ALU whose B operand is the low half of its own 2*WIDTH-bit accumulator. It adds subtraction, carry/zero flags, a start/busy/done handshake, and a multi-cycle shift-add multiplier in place of a combinational `*`. It sits between the board inputs (switches/keys) and the LED/hex display logic, which reads `acc`.

---
 rtl/alu_accum.sv | 150 +++++++++++++++
 tb/tb_alu_accum.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_accum.sv
// rtl/alu_accum.sv - WIDTH-bit accumulator ALU with shift-add multiplier
//
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset, clears all state
//   start  - operation request, sampled only while busy is low
//   op     - operation select, captured with start
//   a      - operand A, captured with start
//   acc    - 2*WIDTH-bit accumulator; operand B is acc[WIDTH-1:0]
//   busy   - high while a multiply is iterating
//   done   - one-cycle pulse after each accumulator update
//   carry  - carry/borrow from the last add/sub
//   zero   - acc is zero after the last update
module alu_accum #(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    output logic [2*WIDTH-1:0]   acc,
    output logic                 busy,
    output logic                 done,
    output logic                 carry,
    output logic                 zero
);

    localparam int AW = 2 * WIDTH;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH:0] SHL_LIM  = (WIDTH + 1)'(AW);
    localparam logic [WIDTH:0] SHR_LIM  = (WIDTH + 1)'(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_LOG = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_RAN = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [AW-1:0]    partial;
    logic [AW-1:0]    partial_next;
    logic [AW-1:0]    alu_result;
    logic             alu_carry;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    assign b    = acc[WIDTH-1:0];
    assign busy = (state == MUL);

    // Single-cycle datapath. The extra top bit of a (W+1)-bit subtraction is
    // exactly the borrow (A < B), so add and sub share the same shape.
    always_comb begin
        sum        = {1'b0, a} + {1'b0, b};
        diff       = {1'b0, a} - {1'b0, b};
        alu_result = '0;
        alu_carry  = carry;
        case (op)
            OP_ADD: begin
                alu_result = AW'(sum);
                alu_carry  = sum[WIDTH];
            end
            OP_SUB: begin
                alu_result = AW'(diff);
                alu_carry  = diff[WIDTH];
            end
            OP_LOG: alu_result = {a | b, a ^ b};
            OP_ROR: alu_result = {{(AW-1){1'b0}}, |{a, b}};
            OP_RAN: alu_result = {{(AW-1){1'b0}}, &{a, b}};
            OP_SHL: alu_result = ({1'b0, a} >= SHL_LIM) ? '0 : (AW'(b) << a);
            OP_SHR: alu_result = ({1'b0, a} >= SHR_LIM) ? '0 : AW'(b >> a);
            default: alu_result = '0;
        endcase
    end

    // One shift-add step: multiplier bit cnt selects A shifted into place.
    always_comb begin
        partial_next = partial;
        if (mul_b[cnt]) begin
            partial_next = partial + (AW'(mul_a) << cnt);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && op == OP_MUL) state_next = MUL;
            MUL:  if (cnt == CNT_LAST)       state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            carry   <= 1'b0;
            zero    <= 1'b1;
            done    <= 1'b0;
            cnt     <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            partial <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            mul_a   <= a;
                            mul_b   <= b;
                            partial <= '0;
                            cnt     <= '0;
                        end else begin
                            acc   <= alu_result;
                            zero  <= (alu_result == '0);
                            carry <= alu_carry;
                            done  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    // acc only sees the final product; partials stay internal.
                    partial <= partial_next;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        acc  <= partial_next;
                        zero <= (partial_next == '0);
                        done <= 1'b1;
                        cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_accum.sv
// tb/tb_alu_accum.sv - scoreboard testbench for alu_accum at WIDTH=4
module tb_alu_accum;

    typedef struct {
        logic [7:0] acc;
        logic       carry;
        logic       zero;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op    = 3'b000;
    logic [3:0] a     = 4'h0;
    logic [7:0] acc;
    logic       busy;
    logic       done;
    logic       carry;
    logic       zero;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_acc    = 0;
    int   m_carry  = 0;

    alu_accum #(.WIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .acc   (acc),
        .busy  (busy),
        .done  (done),
        .carry (carry),
        .zero  (zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model, plain integer arithmetic on the W=4 behaviour.
    task automatic model(input int o, input int x);
        int bb;
        int r;
        bb = m_acc & 15;
        r  = 0;
        case (o)
            0: begin r = x + bb; m_carry = (r >> 4) & 1; end
            1: begin r = ((x - bb) & 15) + ((x < bb) ? 16 : 0); m_carry = (x < bb) ? 1 : 0; end
            2: r = ((x | bb) << 4) | (x ^ bb);
            3: r = ((x | bb) != 0) ? 1 : 0;
            4: r = (x == 15 && bb == 15) ? 1 : 0;
            5: r = (x >= 8) ? 0 : ((bb << x) & 255);
            6: r = (x >= 4) ? 0 : (bb >> x);
            default: r = x * bb;
        endcase
        m_acc = r;
    endtask

    task automatic issue(input logic [2:0] o, input logic [3:0] x, input bit push);
        exp_t e;
        @(negedge clock);
        start = 1'b1;
        op    = o;
        a     = x;
        model(int'(o), int'(x));
        e.acc   = 8'(m_acc);
        e.carry = m_carry[0];
        e.zero  = (m_acc == 0);
        if (push) q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clock);
        check("drain_timeout", q.size(), 0);
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && done) begin
            if (q.size() == 0) begin
                check("spurious_done", {31'b0, done}, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("acc",   {24'b0, acc},   {24'b0, e.acc});
                check("carry", {31'b0, carry}, {31'b0, e.carry});
                check("zero",  {31'b0, zero},  {31'b0, e.zero});
            end
        end
    end

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_acc",   {24'b0, acc}, 32'h00);
            check("rst_zero",  {31'b0, zero}, 1);
            check("rst_carry", {31'b0, carry}, 0);
            check("rst_busy",  {31'b0, busy}, 0);
            check("rst_done",  {31'b0, done}, 0);
        end

        // Back-to-back single-cycle ops with start held high.
        issue(3'b000, 4'h5, 1);
        issue(3'b000, 4'hC, 1);
        issue(3'b001, 4'h3, 1);
        issue(3'b001, 4'h0, 1);
        issue(3'b011, 4'h1, 1);
        issue(3'b101, 4'h7, 1);
        issue(3'b101, 4'h9, 1);
        issue(3'b000, 4'h8, 1);
        issue(3'b110, 4'h4, 1);
        issue(3'b010, 4'hA, 1);
        issue(3'b100, 4'hF, 1);
        issue(3'b000, 4'hF, 1);
        idle();
        check("busy_single", {31'b0, busy}, 0);
        drain();

        // 0x0F * 0x0F, with a stray start in busy cycle 2.
        issue(3'b111, 4'hF, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (i == 0) start = 1'b0;
            check("mul_busy", {31'b0, busy}, 1);
            check("mul_acc_hold", {24'b0, acc}, 32'h0F);
            check("mul_done_low", {31'b0, done}, 0);
            if (i == 1) begin start = 1'b1; op = 3'b000; a = 4'h5; end
            if (i == 2) start = 1'b0;
        end
        @(negedge clock);
        check("mul_busy_end", {31'b0, busy}, 0);
        check("mul_done", {31'b0, done}, 1);
        check("mul_acc", {24'b0, acc}, 32'hE1);
        @(negedge clock);
        check("mul_done_pulse", {31'b0, done}, 0);
        drain();

        // Set carry, then abort a multiply with reset.
        issue(3'b110, 4'h1, 1);
        issue(3'b000, 4'h6, 1);
        issue(3'b001, 4'h0, 1);
        idle();
        drain();
        issue(3'b111, 4'h3, 0);
        idle();
        check("abort_busy1", {31'b0, busy}, 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_acc",   {24'b0, acc}, 32'h00);
        check("abort_busy",  {31'b0, busy}, 0);
        check("abort_done",  {31'b0, done}, 0);
        check("abort_zero",  {31'b0, zero}, 1);
        check("abort_carry", {31'b0, carry}, 0);
        m_acc   = 0;
        m_carry = 0;
        reset   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("abort_no_done", {31'b0, done}, 0);
            check("abort_idle", {31'b0, busy}, 0);
        end
        issue(3'b000, 4'h3, 1);
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
